// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for dmem_port_arbiter: owner and grant encodings, read-return tags
// and the muxed memory request bundle.
package dmem_arb_pkg;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_e;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_CPU,
      GNT_DMA
   } gnt_e;

   typedef struct packed {
      logic   vld;
      owner_e owner;
   } rd_tag_t;

   typedef struct packed {
      logic        wren;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  funct3;
   } mem_req_t;

   localparam rd_tag_t  TAG_NONE = '0;
   localparam mem_req_t REQ_IDLE = '0;

   function automatic owner_e gnt_owner(gnt_e g);
      return (g == GNT_DMA) ? OWN_DMA : OWN_CPU;
   endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the CPU, DMA and memory-side signals around dmem_port_arbiter.
// slave = arbiter view, master = surrounding environment view.
interface dmem_port_arbiter_if;

   logic        i_cpu_req;
   logic        i_cpu_wren;
   logic [31:0] i_cpu_addr;
   logic [31:0] i_cpu_wdata;
   logic [2:0]  i_cpu_funct3;
   logic        o_cpu_stall;
   logic        o_cpu_rvalid;
   logic [31:0] o_cpu_rdata;

   logic        i_dma_req;
   logic        i_dma_wren;
   logic [31:0] i_dma_addr;
   logic [31:0] i_dma_wdata;
   logic [2:0]  i_dma_funct3;
   logic        o_dma_gnt;
   logic        o_dma_rvalid;
   logic [31:0] o_dma_rdata;

   logic        o_mem_req;
   logic        o_mem_wren;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [2:0]  o_mem_funct3;
   logic [31:0] i_mem_rdata;

   modport slave (
      input  i_cpu_req, i_cpu_wren, i_cpu_addr, i_cpu_wdata, i_cpu_funct3,
      output o_cpu_stall, o_cpu_rvalid, o_cpu_rdata,
      input  i_dma_req, i_dma_wren, i_dma_addr, i_dma_wdata, i_dma_funct3,
      output o_dma_gnt, o_dma_rvalid, o_dma_rdata,
      output o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_funct3,
      input  i_mem_rdata
   );

   modport master (
      output i_cpu_req, i_cpu_wren, i_cpu_addr, i_cpu_wdata, i_cpu_funct3,
      input  o_cpu_stall, o_cpu_rvalid, o_cpu_rdata,
      output i_dma_req, i_dma_wren, i_dma_addr, i_dma_wdata, i_dma_funct3,
      input  o_dma_gnt, o_dma_rvalid, o_dma_rdata,
      input  o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_funct3,
      output i_mem_rdata
   );

endinterface

// File: rtl/dmem_port_arbiter_rd_tag_pipe.sv
// RD_LAT-deep shift register of read-return tags; the exiting tag marks which
// owner i_mem_rdata belongs to in the current cycle.
module dmem_rd_tag_pipe
   import dmem_arb_pkg::*;
#(
   parameter int unsigned RD_LAT = 1
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   input  rd_tag_t tag_i,
   output rd_tag_t tag_o
);

   rd_tag_t stage_q [RD_LAT];
   rd_tag_t stage_d [RD_LAT];

   always_comb begin
      stage_d[0] = tag_i;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            stage_q[i] <= TAG_NONE;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign tag_o = stage_q[RD_LAT-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the MEM stage (fixed priority) and a DMA master.
// Optional DMEM_ARB_STARVE_GUARD_EN forces one DMA slot after STARVE_MAX blocked cycles.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic                i_clk,
   input  logic                i_reset,
   dmem_port_arbiter_if.slave  bus
);

   mem_req_t    cpu_req_s;
   mem_req_t    dma_req_s;
   mem_req_t    mem_req_s;
   gnt_e        gnt;
   logic        force_dma;
   rd_tag_t     tag_in;
   rd_tag_t     tag_out;
   logic        cpu_hit;
   logic        dma_hit;
   logic [31:0] cpu_rdata_q, cpu_rdata_d;
   logic [31:0] dma_rdata_q, dma_rdata_d;

   assign cpu_req_s = '{wren: bus.i_cpu_wren, addr: bus.i_cpu_addr,
                        wdata: bus.i_cpu_wdata, funct3: bus.i_cpu_funct3};
   assign dma_req_s = '{wren: bus.i_dma_wren, addr: bus.i_dma_addr,
                        wdata: bus.i_dma_wdata, funct3: bus.i_dma_funct3};

`ifdef DMEM_ARB_STARVE_GUARD_EN
   localparam int unsigned    CNT_W   = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   // Saturating at CNT_MAX means the CPU still wins the cycle it saturates; force starts next cycle.
   assign force_dma = bus.i_dma_req && (wait_cnt_q == CNT_MAX);

   always_comb begin
      wait_cnt_d = '0;
      if (bus.i_dma_req && (gnt != GNT_DMA)) begin
         wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) wait_cnt_q <= '0;
      else          wait_cnt_q <= wait_cnt_d;
   end
`else
   logic unused_starve_max;

   assign force_dma         = 1'b0;
   assign unused_starve_max = |STARVE_MAX;
`endif

   always_comb begin
      gnt = GNT_NONE;
      if (force_dma)            gnt = GNT_DMA;
      else if (bus.i_cpu_req)   gnt = GNT_CPU;
      else if (bus.i_dma_req)   gnt = GNT_DMA;
   end

   always_comb begin
      mem_req_s = REQ_IDLE;
      case (gnt)
         GNT_CPU: mem_req_s = cpu_req_s;
         GNT_DMA: mem_req_s = dma_req_s;
         default: mem_req_s = REQ_IDLE;
      endcase
   end

   assign bus.o_mem_req    = (gnt != GNT_NONE);
   assign bus.o_mem_wren   = mem_req_s.wren;
   assign bus.o_mem_addr   = mem_req_s.addr;
   assign bus.o_mem_wdata  = mem_req_s.wdata;
   assign bus.o_mem_funct3 = mem_req_s.funct3;
   assign bus.o_dma_gnt    = (gnt == GNT_DMA);
   assign bus.o_cpu_stall  = bus.i_cpu_req && (gnt == GNT_DMA);

   assign tag_in = '{vld: (gnt != GNT_NONE) && !mem_req_s.wren, owner: gnt_owner(gnt)};

   dmem_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
      .clk_i  (i_clk),
      .rst_ni (i_reset),
      .tag_i  (tag_in),
      .tag_o  (tag_out)
   );

   // Returning data is forwarded in its arrival cycle and held afterwards.
   assign cpu_hit = tag_out.vld && (tag_out.owner == OWN_CPU);
   assign dma_hit = tag_out.vld && (tag_out.owner == OWN_DMA);

   always_comb begin
      cpu_rdata_d = cpu_hit ? bus.i_mem_rdata : cpu_rdata_q;
      dma_rdata_d = dma_hit ? bus.i_mem_rdata : dma_rdata_q;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

   assign bus.o_cpu_rvalid = cpu_hit;
   assign bus.o_cpu_rdata  = cpu_rdata_d;
   assign bus.o_dma_rvalid = dma_hit;
   assign bus.o_dma_rdata  = dma_rdata_d;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: three instances (RD_LAT 1/2/3) share one request stream
// and are compared each cycle against a transaction-level model of the arbitration rules.
module tb_dmem_port_arbiter;

   localparam int unsigned STARVE = 8;
`ifdef DMEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        cpu_req, cpu_wren, dma_req, dma_wren;
   logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic [2:0]  cpu_f3, dma_f3;

   int unsigned errors = 0;
   int unsigned checks = 0;

   dmem_port_arbiter_if if1 ();
   dmem_port_arbiter_if if2 ();
   dmem_port_arbiter_if if3 ();

   dmem_port_arbiter #(.RD_LAT(1), .STARVE_MAX(STARVE)) dut1 (.i_clk(clk), .i_reset(rst), .bus(if1));
   dmem_port_arbiter #(.RD_LAT(2), .STARVE_MAX(STARVE)) dut2 (.i_clk(clk), .i_reset(rst), .bus(if2));
   dmem_port_arbiter #(.RD_LAT(3), .STARVE_MAX(STARVE)) dut3 (.i_clk(clk), .i_reset(rst), .bus(if3));

   assign {if1.i_cpu_req, if1.i_cpu_wren, if1.i_cpu_addr, if1.i_cpu_wdata, if1.i_cpu_funct3} = {cpu_req, cpu_wren, cpu_addr, cpu_wdata, cpu_f3};
   assign {if1.i_dma_req, if1.i_dma_wren, if1.i_dma_addr, if1.i_dma_wdata, if1.i_dma_funct3} = {dma_req, dma_wren, dma_addr, dma_wdata, dma_f3};
   assign {if2.i_cpu_req, if2.i_cpu_wren, if2.i_cpu_addr, if2.i_cpu_wdata, if2.i_cpu_funct3} = {cpu_req, cpu_wren, cpu_addr, cpu_wdata, cpu_f3};
   assign {if2.i_dma_req, if2.i_dma_wren, if2.i_dma_addr, if2.i_dma_wdata, if2.i_dma_funct3} = {dma_req, dma_wren, dma_addr, dma_wdata, dma_f3};
   assign {if3.i_cpu_req, if3.i_cpu_wren, if3.i_cpu_addr, if3.i_cpu_wdata, if3.i_cpu_funct3} = {cpu_req, cpu_wren, cpu_addr, cpu_wdata, cpu_f3};
   assign {if3.i_dma_req, if3.i_dma_wren, if3.i_dma_addr, if3.i_dma_wdata, if3.i_dma_funct3} = {dma_req, dma_wren, dma_addr, dma_wdata, dma_f3};

   function automatic logic [31:0] pat(logic [7:0] i);
      return {i, ~i, 8'hA5, i};
   endfunction

   // Memory behind each instance: {req, wren, word index, wdata} sampled on the issue edge.
   logic [41:0] mbus [3];
   logic [31:0] bmem [3][256];
   bit          bwr  [3][256];
   logic [31:0] dp   [3][4];

   assign mbus[0] = {if1.o_mem_req, if1.o_mem_wren, if1.o_mem_addr[9:2], if1.o_mem_wdata};
   assign mbus[1] = {if2.o_mem_req, if2.o_mem_wren, if2.o_mem_addr[9:2], if2.o_mem_wdata};
   assign mbus[2] = {if3.o_mem_req, if3.o_mem_wren, if3.o_mem_addr[9:2], if3.o_mem_wdata};
   assign if1.i_mem_rdata = dp[0][0];
   assign if2.i_mem_rdata = dp[1][1];
   assign if3.i_mem_rdata = dp[2][2];

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         for (int j = 3; j > 0; j--) dp[k][j] <= dp[k][j-1];
         if (mbus[k][41] && !mbus[k][40])
            dp[k][0] <= bwr[k][mbus[k][39:32]] ? bmem[k][mbus[k][39:32]] : pat(mbus[k][39:32]);
         else
            dp[k][0] <= 32'hBAD0_BAD0;
         if (mbus[k][41] && mbus[k][40]) begin
            bmem[k][mbus[k][39:32]] <= mbus[k][31:0];
            bwr[k][mbus[k][39:32]]  <= 1'b1;
         end
      end
   end

   // Reference model: memory image, reads due at issue+latency per instance, wait counter.
   logic [31:0] mm [256];
   bit          pend_vld  [3][8];
   bit          pend_own  [3][8];
   logic [31:0] pend_data [3][8];
   logic [31:0] exp_crd [3];
   logic [31:0] exp_drd [3];
   bit          exp_crv [3];
   bit          exp_drv [3];
   int unsigned mcnt = 0;
   int unsigned cyc = 0;
   int unsigned issued;
   bit e_gnt, e_cpu_win, e_stall, last_stall, last_gnt;

   task automatic chk1(string tag, int k, logic obs, logic want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s[%0d] observed=%b expected=%b", tag, k, obs, want);
      end
   endtask

   task automatic chk32(string tag, int k, logic [31:0] obs, logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, want);
      end
   endtask

   task automatic chk_inst(int k, logic stall, logic gnt, logic mreq, logic mwren,
                           logic [31:0] maddr, logic [31:0] mwdata, logic [2:0] mf3,
                           logic crv, logic [31:0] crd, logic drv, logic [31:0] drd);
      chk1("cpu_stall", k, stall, e_stall);
      chk1("dma_gnt", k, gnt, e_gnt);
      chk1("mem_req", k, mreq, e_gnt || e_cpu_win);
      chk1("mem_wren", k, mwren, e_gnt ? dma_wren : (e_cpu_win ? cpu_wren : 1'b0));
      if (e_gnt || e_cpu_win) begin
         chk32("mem_addr", k, maddr, e_gnt ? dma_addr : cpu_addr);
         chk32("mem_wdata", k, mwdata, e_gnt ? dma_wdata : cpu_wdata);
         chk32("mem_funct3", k, {29'd0, mf3}, {29'd0, e_gnt ? dma_f3 : cpu_f3});
      end
      chk1("cpu_rvalid", k, crv, exp_crv[k]);
      chk32("cpu_rdata", k, crd, exp_crd[k]);
      chk1("dma_rvalid", k, drv, exp_drv[k]);
      chk32("dma_rdata", k, drd, exp_drd[k]);
   endtask

   task automatic cyc_check();
      int s;
      bit force_dma;
      force_dma = GUARD && dma_req && (mcnt == STARVE);
      e_gnt     = force_dma || (dma_req && !cpu_req);
      e_cpu_win = cpu_req && !e_gnt;
      e_stall   = cpu_req && e_gnt;
      @(negedge clk);
      s = int'(cyc % 8);
      for (int k = 0; k < 3; k++) begin
         exp_crv[k] = pend_vld[k][s] && !pend_own[k][s];
         exp_drv[k] = pend_vld[k][s] && pend_own[k][s];
         if (exp_crv[k]) exp_crd[k] = pend_data[k][s];
         if (exp_drv[k]) exp_drd[k] = pend_data[k][s];
      end
      chk_inst(0, if1.o_cpu_stall, if1.o_dma_gnt, if1.o_mem_req, if1.o_mem_wren, if1.o_mem_addr, if1.o_mem_wdata,
               if1.o_mem_funct3, if1.o_cpu_rvalid, if1.o_cpu_rdata, if1.o_dma_rvalid, if1.o_dma_rdata);
      chk_inst(1, if2.o_cpu_stall, if2.o_dma_gnt, if2.o_mem_req, if2.o_mem_wren, if2.o_mem_addr, if2.o_mem_wdata,
               if2.o_mem_funct3, if2.o_cpu_rvalid, if2.o_cpu_rdata, if2.o_dma_rvalid, if2.o_dma_rdata);
      chk_inst(2, if3.o_cpu_stall, if3.o_dma_gnt, if3.o_mem_req, if3.o_mem_wren, if3.o_mem_addr, if3.o_mem_wdata,
               if3.o_mem_funct3, if3.o_cpu_rvalid, if3.o_cpu_rdata, if3.o_dma_rvalid, if3.o_dma_rdata);
   endtask

   task automatic cyc_adv();
      logic [31:0] a;
      @(posedge clk);
      #1;
      if (rst) begin
         for (int k = 0; k < 3; k++) pend_vld[k][cyc % 8] = 1'b0;
         if (dma_req && !e_gnt) mcnt = (mcnt < STARVE) ? mcnt + 1 : mcnt;
         else                   mcnt = 0;
         if (e_gnt || e_cpu_win) begin
            a = e_gnt ? dma_addr : cpu_addr;
            if (e_gnt ? dma_wren : cpu_wren) begin
               mm[a[9:2]] = e_gnt ? dma_wdata : cpu_wdata;
            end else begin
               for (int k = 0; k < 3; k++) begin
                  pend_vld[k][(cyc + k + 1) % 8]  = 1'b1;
                  pend_own[k][(cyc + k + 1) % 8]  = e_gnt;
                  pend_data[k][(cyc + k + 1) % 8] = mm[a[9:2]];
               end
            end
         end
      end
      last_stall = e_stall;
      last_gnt   = e_gnt;
      cyc++;
   endtask

   task automatic cycle();
      cyc_check();
      cyc_adv();
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         for (int s = 0; s < 8; s++) pend_vld[k][s] = 1'b0;
         exp_crd[k] = '0;
         exp_drd[k] = '0;
      end
      mcnt = 0;
   endtask

   task automatic set_cpu(logic req, logic wren, logic [31:0] addr, logic [31:0] wdata);
      cpu_req = req; cpu_wren = wren; cpu_addr = addr; cpu_wdata = wdata; cpu_f3 = 3'b010;
   endtask

   task automatic set_dma(logic req, logic wren, logic [31:0] addr, logic [31:0] wdata);
      dma_req = req; dma_wren = wren; dma_addr = addr; dma_wdata = wdata; dma_f3 = 3'b100;
   endtask

   task automatic run_idle(int n);
      set_cpu(1'b0, 1'b0, '0, '0);
      set_dma(1'b0, 1'b0, '0, '0);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mm[i] = pat(8'(i));
      rst = 1'b0;
      model_reset();
      last_stall = 1'b0;
      last_gnt   = 1'b0;
      run_idle(2);
      rst = 1'b1;
      run_idle(1);

      // CPU load alone, data back one cycle later on the RD_LAT=1 instance
      set_cpu(1'b1, 1'b0, 32'h100, '0);
      cycle();
      set_cpu(1'b0, 1'b0, '0, '0);
      cyc_check();
      chk1("t1_cpu_rvalid", 0, if1.o_cpu_rvalid, 1'b1);
      chk32("t1_cpu_rdata", 0, if1.o_cpu_rdata, pat(8'h40));
      chk1("t1_dma_rvalid", 0, if1.o_dma_rvalid, 1'b0);
      cyc_adv();
      run_idle(3);

      // Simultaneous stores: CPU first, DMA once CPU idles, then read both back
      set_cpu(1'b1, 1'b1, 32'h40, 32'h1111_2222);
      set_dma(1'b1, 1'b1, 32'h44, 32'h3333_4444);
      cycle();
      set_cpu(1'b0, 1'b0, '0, '0);
      cycle();
      set_dma(1'b0, 1'b0, '0, '0);
      set_cpu(1'b1, 1'b0, 32'h40, '0);
      cycle();
      set_cpu(1'b1, 1'b0, 32'h44, '0);
      cycle();
      run_idle(4);

      // Alternating CPU/DMA reads every cycle
      for (int i = 0; i < 8; i++) begin
         set_cpu(i % 2 == 0, 1'b0, 32'h10, '0);
         set_dma(i % 2 == 1, 1'b0, 32'h20, '0);
         cycle();
      end
      run_idle(4);

      // Twenty CPU loads against a waiting DMA load
      set_dma(1'b1, 1'b0, 32'h80, '0);
      issued = 0;
      for (int it = 0; it < 30 && issued < 20; it++) begin
         set_cpu(1'b1, 1'b0, 32'h200 + issued * 4, '0);
         cyc_check();
         chk1("t4_dma_gnt", 1, if2.o_dma_gnt, GUARD && (it == 8));
         chk1("t4_cpu_stall", 1, if2.o_cpu_stall, GUARD && (it == 8));
         cyc_adv();
         if (!last_stall) issued++;
         if (last_gnt) dma_req = 1'b0;
      end
      set_cpu(1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 4 && dma_req; i++) begin
         cycle();
         if (last_gnt) dma_req = 1'b0;
      end
      chk1("t5_dma_served", 0, dma_req, 1'b0);
      run_idle(4);

      // Random traffic: CPU holds while stalled, DMA holds until granted
      for (int n = 0; n < 120; n++) begin
         if (!(cpu_req && last_stall)) begin
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_wren  = 1'($urandom_range(0, 1));
            cpu_addr  = 32'h300 + (32'($urandom_range(0, 15)) << 2);
            cpu_wdata = $urandom;
            cpu_f3    = 3'($urandom_range(0, 7));
         end
         if (!(dma_req && !last_gnt)) begin
            dma_req   = 1'($urandom_range(0, 1));
            dma_wren  = 1'($urandom_range(0, 1));
            dma_addr  = 32'h300 + (32'($urandom_range(0, 15)) << 2);
            dma_wdata = $urandom;
            dma_f3    = 3'($urandom_range(0, 7));
         end
         cycle();
      end
      run_idle(4);

      // Reset with two reads in flight
      set_cpu(1'b1, 1'b0, 32'h100, '0);
      cycle();
      set_cpu(1'b0, 1'b0, '0, '0);
      set_dma(1'b1, 1'b0, 32'h104, '0);
      cycle();
      set_dma(1'b0, 1'b0, '0, '0);
      rst = 1'b0;
      model_reset();
      cycle();
      cycle();
      rst = 1'b1;
      run_idle(4);
      chk32("t6_cpu_rdata", 1, if2.o_cpu_rdata, 32'h0);
      chk32("t6_dma_rdata", 1, if2.o_dma_rdata, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
